// File: rtl/csu_16_serial.sv
`default_nettype none
// ============================================================================
// Module   : csu_16_serial
// Purpose  : Slice-serial subtractor. Computes d = a - b - bi one SLICE-bit
//            slice per clock, least significant slice first, reusing a single
//            SLICE+1 bit datapath. Start/done handshake; results and flags
//            hold until the next completed operation.
// Options  : `define CSU_ADD_MODE_EN adds a 'sub' input. When sub=0 the
//            block computes d = a + b + bi on the same datapath, and bo
//            reports carry out.
// Revision : 1.0 - initial release
// ============================================================================
module csu_16_serial #(
  parameter int WIDTH = 16,
  parameter int SLICE = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
`ifdef CSU_ADD_MODE_EN
  input  logic             sub,
`endif
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bi,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] d,
  output logic             bo,
  output logic             zero,
  output logic             neg,
  output logic             ovf
);

  // WIDTH is expected to be an exact multiple of SLICE.
  localparam int NSLICE = WIDTH / SLICE;
  localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [CW-1:0] LAST_SLICE = CW'(NSLICE - 1);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  // --------------------------------------------------------------------------
  // State, operand and result registers
  // --------------------------------------------------------------------------
  logic [0:0]       state_q,  state_d;
  logic [CW-1:0]    cnt_q,    cnt_d;
  logic [WIDTH-1:0] a_op_q,   a_op_d;
  logic [WIDTH-1:0] b_op_q,   b_op_d;
  logic             chain_q,  chain_d;   // borrow (subtract) or carry (add)
  logic [WIDTH-1:0] shadow_q, shadow_d;  // partial result, hidden from d
  logic [WIDTH-1:0] d_q,      d_d;
  logic             bo_q,     bo_d;
  logic             zero_q,   zero_d;
  logic             neg_q,    neg_d;
  logic             ovf_q,    ovf_d;
  logic             done_q,   done_d;

  // High when the latched operation is a subtraction.
  logic             is_sub;

`ifdef CSU_ADD_MODE_EN
  logic             sub_op_q, sub_op_d;
  assign is_sub = sub_op_q;
`else
  assign is_sub = 1'b1;
`endif

  // --------------------------------------------------------------------------
  // Slice datapath
  // --------------------------------------------------------------------------
  logic [SLICE-1:0] a_sl;
  logic [SLICE-1:0] b_sl;
  logic [SLICE-1:0] b_eff;
  logic             cin;
  logic [SLICE:0]   sum;
  logic [SLICE-1:0] slice_res;
  logic             chain_nxt;
  logic [WIDTH-1:0] shadow_upd;
  logic             a_msb;
  logic             b_msb;
  logic             r_msb;
  logic             ovf_nxt;

  // Select the operand slice addressed by the slice counter.
  always_comb begin
    a_sl = '0;
    b_sl = '0;
    for (int i = 0; i < NSLICE; i++) begin
      if (cnt_q == CW'(i)) begin
        a_sl = a_op_q[i*SLICE +: SLICE];
        b_sl = b_op_q[i*SLICE +: SLICE];
      end
    end
  end

  // One SLICE+1 bit adder serves both modes. Subtraction is a + ~b + ~borrow,
  // so the borrow is the inverse of the carry out; addition uses the chain
  // register directly as carry.
  always_comb begin
    b_eff     = is_sub ? ~b_sl : b_sl;
    cin       = is_sub ? ~chain_q : chain_q;
    sum       = {1'b0, a_sl} + {1'b0, b_eff} + {{SLICE{1'b0}}, cin};
    slice_res = sum[SLICE-1:0];
    chain_nxt = is_sub ? ~sum[SLICE] : sum[SLICE];
  end

  // Merge this cycle's slice into the shadow result.
  always_comb begin
    shadow_upd = shadow_q;
    for (int i = 0; i < NSLICE; i++) begin
      if (cnt_q == CW'(i)) begin
        shadow_upd[i*SLICE +: SLICE] = slice_res;
      end
    end
  end

  // Signed overflow of the complete result, including the slice written now.
  always_comb begin
    a_msb = a_op_q[WIDTH-1];
    b_msb = b_op_q[WIDTH-1];
    r_msb = shadow_upd[WIDTH-1];
    if (is_sub) begin
      ovf_nxt = (a_msb != b_msb) && (r_msb != a_msb);
    end else begin
      ovf_nxt = (a_msb == b_msb) && (r_msb != a_msb);
    end
  end

  // --------------------------------------------------------------------------
  // Control: accept in IDLE, walk the slices in RUN, publish on the last one
  // --------------------------------------------------------------------------
  // Next-state logic for the sequencer, operand latch and result registers.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_op_d   = a_op_q;
    b_op_d   = b_op_q;
    chain_d  = chain_q;
    shadow_d = shadow_q;
    d_d      = d_q;
    bo_d     = bo_q;
    zero_d   = zero_q;
    neg_d    = neg_q;
    ovf_d    = ovf_q;
    done_d   = 1'b0;
`ifdef CSU_ADD_MODE_EN
    sub_op_d = sub_op_q;
`endif

    case (state_q)
      IDLE: begin
        // Also reached during the done cycle, giving back-to-back issue.
        if (start) begin
          a_op_d   = a;
          b_op_d   = b;
          chain_d  = bi;
          cnt_d    = '0;
          shadow_d = '0;
          state_d  = RUN;
`ifdef CSU_ADD_MODE_EN
          sub_op_d = sub;
`endif
        end
      end

      RUN: begin
        // start is ignored here; the latched operands stay untouched.
        shadow_d = shadow_upd;
        chain_d  = chain_nxt;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == LAST_SLICE) begin
          cnt_d   = '0;
          state_d = IDLE;
          done_d  = 1'b1;
          d_d     = shadow_upd;
          bo_d    = chain_nxt;
          zero_d  = ~|shadow_upd;
          neg_d   = shadow_upd[WIDTH-1];
          ovf_d   = ovf_nxt;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Register update with asynchronous clear; reset aborts any operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      a_op_q   <= '0;
      b_op_q   <= '0;
      chain_q  <= 1'b0;
      shadow_q <= '0;
      d_q      <= '0;
      bo_q     <= 1'b0;
      zero_q   <= 1'b0;
      neg_q    <= 1'b0;
      ovf_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_op_q   <= a_op_d;
      b_op_q   <= b_op_d;
      chain_q  <= chain_d;
      shadow_q <= shadow_d;
      d_q      <= d_d;
      bo_q     <= bo_d;
      zero_q   <= zero_d;
      neg_q    <= neg_d;
      ovf_q    <= ovf_d;
      done_q   <= done_d;
    end
  end

`ifdef CSU_ADD_MODE_EN
  // Mode bit travels with the operands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sub_op_q <= 1'b0;
    end else begin
      sub_op_q <= sub_op_d;
    end
  end
`endif

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign busy = (state_q == RUN);
  assign done = done_q;
  assign d    = d_q;
  assign bo   = bo_q;
  assign zero = zero_q;
  assign neg  = neg_q;
  assign ovf  = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_csu_16_serial.sv
`default_nettype none
// ============================================================================
// Module   : tb_csu_16_serial
// Purpose  : Scoreboard bench for csu_16_serial. Directed operations push
//            their hand-computed results into a queue; a monitor pops and
//            compares on every done pulse. Build with CSU_ADD_MODE_EN to
//            cover the add mode as well.
// Revision : 1.0 - initial release
// ============================================================================
module tb_csu_16_serial;

  typedef struct packed {
    logic [15:0] d;
    logic        bo;
    logic        zero;
    logic        neg;
    logic        ovf;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] a;
  logic [15:0] b;
  logic        bi;
  logic        busy;
  logic        done;
  logic [15:0] d;
  logic        bo;
  logic        zero;
  logic        neg;
  logic        ovf;
`ifdef CSU_ADD_MODE_EN
  logic        sub_r;
`endif

  exp_t sb[$];
  int   checks;
  int   errors;

  csu_16_serial #(.WIDTH(16), .SLICE(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
`ifdef CSU_ADD_MODE_EN
    .sub   (sub_r),
`endif
    .a     (a),
    .b     (b),
    .bi    (bi),
    .busy  (busy),
    .done  (done),
    .d     (d),
    .bo    (bo),
    .zero  (zero),
    .neg   (neg),
    .ovf   (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && done === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1 expected no result pending at %0t", $time);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("d",    32'(d),    32'(e.d));
        chk("bo",   32'(bo),   32'(e.bo));
        chk("zero", 32'(zero), 32'(e.zero));
        chk("neg",  32'(neg),  32'(e.neg));
        chk("ovf",  32'(ovf),  32'(e.ovf));
      end
    end
  end

  // Issue one operation (called #1 after a rising edge) and check the
  // busy/done timing: done exactly on the 4th edge after acceptance.
  task automatic do_op(input logic [15:0] av, input logic [15:0] bv, input logic biv,
                       input logic [15:0] ed, input logic ebo, input logic ez,
                       input logic en, input logic eo);
    exp_t e;
    e = '{d: ed, bo: ebo, zero: ez, neg: en, ovf: eo};
    a     = av;
    b     = bv;
    bi    = biv;
    start = 1'b1;
    sb.push_back(e);
    @(posedge clk); #1;
    start = 1'b0;
    // Operand changes after acceptance must not matter.
    a  = 16'(~av);
    b  = 16'(~bv);
    bi = ~biv;
    chk("busy_after_accept", 32'(busy), 32'd1);
    for (int i = 1; i <= 4; i++) begin
      @(posedge clk); #1;
      if (i < 4) begin
        chk("done_early", 32'(done), 32'd0);
      end else begin
        chk("done_on_time", 32'(done), 32'd1);
        chk("busy_at_done", 32'(busy), 32'd0);
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    start  = 1'b0;
    a      = '0;
    b      = '0;
    bi     = 1'b0;
`ifdef CSU_ADD_MODE_EN
    sub_r  = 1'b1;
`endif
    #12;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_d",    32'(d),    32'd0);
    chk("rst_flags", 32'({bo, zero, neg, ovf}), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Basic subtract, underflow, signed overflow, borrow-in to zero.
    do_op(16'h0005, 16'h0003, 1'b0, 16'h0002, 1'b0, 1'b0, 1'b0, 1'b0);
    do_op(16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b1, 1'b0);
    do_op(16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b0, 1'b0, 1'b1);
    // Back-to-back: issued in the done cycle of the previous operation.
    do_op(16'h1234, 16'h1233, 1'b1, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0);
    do_op(16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b0, 1'b1, 1'b1);
    do_op(16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b1, 1'b0);
    // Result holds after done.
    @(posedge clk); #1;
    chk("hold_d", 32'(d), 32'hFFFF);

    // A second start while busy is ignored.
    a     = 16'h00F0;
    b     = 16'h000F;
    bi    = 1'b0;
    start = 1'b1;
    sb.push_back('{d: 16'h00E1, bo: 1'b0, zero: 1'b0, neg: 1'b0, ovf: 1'b0});
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    a     = 16'hFFFF;
    b     = 16'hFFFF;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("busy_ignore", 32'(busy), 32'd1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("done_ignore", 32'(done), 32'd1);
    repeat (6) @(posedge clk);
    #1;
    chk("single_done_d", 32'(d), 32'h00E1);

    // Reset mid-operation aborts with no done.
    a     = 16'h5555;
    b     = 16'h1111;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_d",    32'(d),    32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    chk("abort_no_done_d", 32'(d), 32'd0);
    chk("abort_idle", 32'(busy), 32'd0);

    // Recovery after abort.
    do_op(16'h0003, 16'h0005, 1'b0, 16'hFFFE, 1'b1, 1'b0, 1'b1, 1'b0);

`ifdef CSU_ADD_MODE_EN
    sub_r = 1'b0;
    do_op(16'hFFFE, 16'h0001, 1'b1, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0);
    do_op(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b0, 1'b1, 1'b1);
    sub_r = 1'b1;
    do_op(16'h0005, 16'h0003, 1'b0, 16'h0002, 1'b0, 1'b0, 1'b0, 1'b0);
`endif

    repeat (4) @(posedge clk);
    #1;
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
